// File: rtl/fb_sequencer.sv
// Frame-buffer sequencer: gates camera writes on whole-frame boundaries after
// configuration and settle frames, and streams a crop window to the OLED.
module fb_sequencer #(
    parameter int IMG_COLS    = 320,
    parameter int IMG_ROWS    = 240,
    parameter int WIN_W       = 128,
    parameter int WIN_H       = 128,
    parameter int X_OFF       = 96,
    parameter int Y_OFF       = 56,
    parameter int SKIP_FRAMES = 4,
    parameter int AW          = 17,
    parameter int DW          = 16
) (
    input  logic          oclk,
    input  logic          rst,
    input  logic          cfg_done,
    input  logic          cam_vsync,
    input  logic          btn_freeze,
    input  logic          btn_resume,
    input  logic          cap_we_in,
    output logic          cap_we_out,
    output logic [AW-1:0] fb_rd_addr,
    input  logic [DW-1:0] fb_rd_data,
    input  logic          next_pixel,
    output logic [DW-1:0] color,
    output logic [7:0]    frame_cnt,
    output logic [2:0]    state,
    output logic          frozen
);

    // state       | meaning
    // WAIT_CFG    | camera not configured; gate closed, display idle
    // SKIP        | discarding settle frames after configuration
    // LIVE        | gate open, frames stream into the buffer
    // FREEZE_PEND | freeze requested; gate closes at next frame boundary
    // FROZEN      | gate closed, buffer holds the last complete frame
    // RESUME_PEND | resume requested; gate opens at next frame boundary
    typedef enum logic [2:0] {
        WAIT_CFG    = 3'd0,
        SKIP        = 3'd1,
        LIVE        = 3'd2,
        FREEZE_PEND = 3'd3,
        FROZEN      = 3'd4,
        RESUME_PEND = 3'd5
    } state_t;

    localparam int XW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int YW = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam logic [AW-1:0] ROW0   = AW'(Y_OFF * IMG_COLS);
    localparam logic [AW-1:0] STRIDE = AW'(IMG_COLS);
    localparam logic [AW-1:0] XOFF   = AW'(X_OFF);
    localparam logic [XW-1:0] X_LAST = XW'(WIN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(WIN_H - 1);
    localparam logic [7:0]    SKIP8  = 8'(SKIP_FRAMES);

    if (X_OFF + WIN_W > IMG_COLS) begin : g_bad_x
        $error("fb_sequencer: crop window exceeds image width");
    end
    if (Y_OFF + WIN_H > IMG_ROWS) begin : g_bad_y
        $error("fb_sequencer: crop window exceeds image height");
    end
    if (SKIP_FRAMES < 1 || SKIP_FRAMES > 255) begin : g_bad_skip
        $error("fb_sequencer: SKIP_FRAMES out of range");
    end

    state_t        state_q, state_d;
    logic          vs1, vs2, vs3, fb;
    logic          frz_q, res_q;
    logic          frz_edge, res_edge;
    logic          fc_inc;
    logic          gate;
    logic [7:0]    skip_cnt;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [AW-1:0] rowbase;
    logic          disp_on;

    // fb is a registered one-cycle pulse: two sync flops plus the edge register
    always_ff @(posedge oclk) begin
        if (rst) begin
            vs1   <= 1'b0;
            vs2   <= 1'b0;
            vs3   <= 1'b0;
            fb    <= 1'b0;
            frz_q <= 1'b0;
            res_q <= 1'b0;
        end else begin
            vs1   <= cam_vsync;
            vs2   <= vs1;
            vs3   <= vs2;
            fb    <= vs2 & ~vs3;
            frz_q <= btn_freeze;
            res_q <= btn_resume;
        end
    end

    assign frz_edge = btn_freeze & ~frz_q;
    assign res_edge = btn_resume & ~res_q;

    always_comb begin
        state_d = state_q;
        fc_inc  = 1'b0;
        if (!cfg_done) begin
            state_d = WAIT_CFG;
        end else begin
            case (state_q)
                WAIT_CFG: state_d = SKIP;
                SKIP: if (fb && skip_cnt == 8'd1) state_d = LIVE;
                LIVE: begin
                    if (fb) fc_inc = 1'b1;
                    if (frz_edge) state_d = FREEZE_PEND;
                end
                FREEZE_PEND: begin
                    // a cancel in the same cycle as a boundary takes priority
                    if (res_edge) begin
                        state_d = LIVE;
                    end else if (fb) begin
                        state_d = FROZEN;
                        fc_inc  = 1'b1;
                    end
                end
                FROZEN: if (res_edge) state_d = RESUME_PEND;
                RESUME_PEND: begin
                    if (frz_edge) state_d = FROZEN;
                    else if (fb)  state_d = LIVE;
                end
                default: state_d = WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge oclk) begin
        if (rst) begin
            state_q   <= WAIT_CFG;
            gate      <= 1'b0;
            frame_cnt <= 8'd0;
            skip_cnt  <= SKIP8;
        end else begin
            state_q <= state_d;
            gate    <= (state_d == LIVE) || (state_d == FREEZE_PEND);
            if (fc_inc) frame_cnt <= frame_cnt + 8'd1;
            if (state_q == WAIT_CFG)     skip_cnt <= SKIP8;
            else if (state_q == SKIP && fb) skip_cnt <= skip_cnt - 8'd1;
        end
    end

    assign disp_on = (state_q == LIVE) || (state_q == FREEZE_PEND) ||
                     (state_q == FROZEN) || (state_q == RESUME_PEND);

    // window counters survive freeze/resume so the OLED raster stays aligned
    always_ff @(posedge oclk) begin
        if (rst || !disp_on) begin
            wx      <= '0;
            wy      <= '0;
            rowbase <= ROW0;
            color   <= '0;
        end else if (next_pixel) begin
            color <= fb_rd_data;
            if (wx == X_LAST) begin
                wx <= '0;
                if (wy == Y_LAST) begin
                    wy      <= '0;
                    rowbase <= ROW0;
                end else begin
                    wy      <= wy + 1'b1;
                    rowbase <= rowbase + STRIDE;
                end
            end else begin
                wx <= wx + 1'b1;
            end
        end
    end

    assign fb_rd_addr = rowbase + XOFF + AW'(wx);
    assign cap_we_out = cap_we_in & gate;
    assign state      = state_q;
    assign frozen     = (state_q == FROZEN) || (state_q == RESUME_PEND);

endmodule

// File: tb/tb_fb_sequencer.sv
// Directed bench for fb_sequencer: frame gating, freeze/resume, crop-window
// address walk and cfg_done drop.
module tb_fb_sequencer;

    logic        oclk = 1'b0;
    logic        rst, cfg_done, cam_vsync, btn_freeze, btn_resume;
    logic        cap_we_in, cap_we_out, next_pixel, frozen;
    logic [16:0] fb_rd_addr;
    logic [15:0] fb_rd_data, color;
    logic [7:0]  frame_cnt;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    fb_sequencer dut (
        .oclk(oclk), .rst(rst), .cfg_done(cfg_done), .cam_vsync(cam_vsync),
        .btn_freeze(btn_freeze), .btn_resume(btn_resume),
        .cap_we_in(cap_we_in), .cap_we_out(cap_we_out),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .next_pixel(next_pixel), .color(color), .frame_cnt(frame_cnt),
        .state(state), .frozen(frozen)
    );

    always #5 oclk = ~oclk;

    // buffer model: each word holds its own address, one-cycle read latency
    always @(posedge oclk) fb_rd_data <= fb_rd_addr[15:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge oclk);
        #1;
    endtask

    // one 1000-cycle camera frame starting with a VSYNC rise
    task automatic frame(input logic [2:0] s_before, input logic [2:0] s_after,
                         input logic g_after, input logic [7:0] fc);
        cam_vsync = 1'b1;
        step(3);
        check("fb_pre_state", 32'(state), 32'(s_before));
        step(1);
        check("fb_post_state", 32'(state), 32'(s_after));
        for (int i = 0; i < 996; i++) begin
            if (i == 20) cam_vsync = 1'b0;
            cap_we_in = 1'($urandom_range(0, 1));
            #1;
            if (i % 50 == 0) check("we_gate", 32'(cap_we_out), 32'(cap_we_in & g_after));
            step(1);
        end
        check("frame_cnt", 32'(frame_cnt), 32'(fc));
    endtask

    task automatic pulse_btn(input bit frz, input bit res);
        btn_freeze = frz;
        btn_resume = res;
        step(1);
        btn_freeze = 1'b0;
        btn_resume = 1'b0;
        step(1);
    endtask

    initial begin
        logic [16:0] exp_addr;
        int kk;
        rst = 1'b1; cfg_done = 1'b0; cam_vsync = 1'b0; btn_freeze = 1'b0;
        btn_resume = 1'b0; cap_we_in = 1'b1; next_pixel = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_state", 32'(state), 0);
        check("rst_we", 32'(cap_we_out), 0);
        check("rst_addr", 32'(fb_rd_addr), 18016);
        check("rst_color", 32'(color), 0);
        check("rst_fc", 32'(frame_cnt), 0);
        check("rst_frozen", 32'(frozen), 0);

        cfg_done = 1'b1;
        step(1);
        check("skip_entry", 32'(state), 1);
        next_pixel = 1'b1; step(1); next_pixel = 1'b0; step(1);
        check("skip_np_addr", 32'(fb_rd_addr), 18016);
        check("skip_np_color", 32'(color), 0);

        repeat (3) frame(3'd1, 3'd1, 1'b0, 8'd0);
        frame(3'd1, 3'd2, 1'b1, 8'd0);
        frame(3'd2, 3'd2, 1'b1, 8'd1);

        for (int k = 0; k <= 16384; k++) begin
            kk = k % 16384;
            exp_addr = 17'(18016 + (kk / 128) * 320 + (kk % 128));
            check("rd_addr", 32'(fb_rd_addr), 32'(exp_addr));
            next_pixel = 1'b1;
            step(1);
            next_pixel = 1'b0;
            check("color", 32'(color), 32'(exp_addr[15:0]));
            step(3);
        end
        check("addr_after_wrap", 32'(fb_rd_addr), 18017);

        pulse_btn(1'b1, 1'b0);
        check("freeze_pend", 32'(state), 3);
        cap_we_in = 1'b1; #1;
        check("pend_we_open", 32'(cap_we_out), 1);
        frame(3'd3, 3'd4, 1'b0, 8'd2);
        check("frozen_flag", 32'(frozen), 1);
        repeat (3) frame(3'd4, 3'd4, 1'b0, 8'd2);

        pulse_btn(1'b0, 1'b1);
        check("resume_pend", 32'(state), 5);
        check("resume_frozen", 32'(frozen), 1);
        cap_we_in = 1'b1; #1;
        check("resume_we_closed", 32'(cap_we_out), 0);
        frame(3'd5, 3'd2, 1'b1, 8'd2);
        check("live_frozen", 32'(frozen), 0);

        pulse_btn(1'b1, 1'b1);
        check("both_edges_live", 32'(state), 3);
        cam_vsync = 1'b1;
        step(3);
        btn_resume = 1'b1;
        step(1);
        check("cancel_wins_state", 32'(state), 2);
        check("cancel_wins_fc", 32'(frame_cnt), 2);
        btn_resume = 1'b0; cam_vsync = 1'b0;
        step(20);

        pulse_btn(1'b1, 1'b0);
        frame(3'd3, 3'd4, 1'b0, 8'd3);
        pulse_btn(1'b1, 1'b1);
        check("both_edges_frozen", 32'(state), 5);
        pulse_btn(1'b1, 1'b0);
        check("resume_cancel", 32'(state), 4);
        pulse_btn(1'b0, 1'b1);
        frame(3'd5, 3'd2, 1'b1, 8'd3);

        cap_we_in = 1'b1;
        cfg_done = 1'b0;
        step(1);
        check("drop_state", 32'(state), 0);
        check("drop_we", 32'(cap_we_out), 0);
        step(1);
        check("drop_addr", 32'(fb_rd_addr), 18016);
        check("drop_color", 32'(color), 0);
        cfg_done = 1'b1;
        step(1);
        check("reskip_entry", 32'(state), 1);
        repeat (3) frame(3'd1, 3'd1, 1'b0, 8'd3);
        frame(3'd1, 3'd2, 1'b1, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
